// File: rtl/cordic_pkg.sv
// cordic_pkg
// Shared helpers for the CORDIC scheduler slice.
//   clog2        : ceiling log2, used for ID and counter widths
//   cordic_lat   : pipeline latency of the shared rotator for a given operand width
//   ANGLE_90/45  : 32-bit angle encoding, full circle = 2^32
package cordic_pkg;

    localparam logic [31:0] ANGLE_90 = 32'h4000_0000;
    localparam logic [31:0] ANGLE_45 = 32'h2000_0000;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // The rotator retires one micro-rotation per operand bit.
    function automatic int cordic_lat(input int xy_sz);
        return xy_sz;
    endfunction

endpackage

// File: rtl/cordic_res_fifo.sv
// cordic_res_fifo
// Synchronous first-word-fall-through FIFO holding rotator results.
//   clock, reset : posedge clock, synchronous active-high reset
//   push         : write push_data (ignored when full unless popping)
//   pop          : drop the head entry (ignored when empty)
//   head_data    : current head, valid whenever empty is low
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
module cordic_res_fifo import cordic_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [clog2(DEPTH+1)-1:0]  count
);

    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths would still work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_pop    = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state; reset empties the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cordic_sched.sv
// cordic_sched
// Round-robin scheduler sharing one non-stallable pipelined CORDIC rotator
// between NREQ requesters. Results are collected in a FWFT FIFO; a credit
// counter (in flight + buffered) keeps the FIFO from ever overflowing.
//   clock, reset            : posedge clock, synchronous active-high reset
//   req_valid/req_ready     : per-requester handshake, req_ready is one-hot
//   req_angle/req_x/req_y   : flattened per-requester operands
//   cx_angle/cx_xin/cx_yin  : registered operands into the rotator
//   cx_xout/cx_yout         : rotator outputs, LAT cycles after cx_* update
//   res_valid/res_ready     : result handshake from the FIFO head
//   res_id/res_x/res_y      : issuing requester and rotated vector
module cordic_sched import cordic_pkg::*; #(
    parameter int NREQ       = 4,
    parameter int XY_SZ      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int ID_W       = clog2(NREQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*32-1:0]      req_angle,
    input  logic [NREQ*XY_SZ-1:0]   req_x,
    input  logic [NREQ*XY_SZ-1:0]   req_y,
    output logic [31:0]             cx_angle,
    output logic [XY_SZ-1:0]        cx_xin,
    output logic [XY_SZ-1:0]        cx_yin,
    input  logic [XY_SZ:0]          cx_xout,
    input  logic [XY_SZ:0]          cx_yout,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic [XY_SZ:0]          res_x,
    output logic [XY_SZ:0]          res_y
);

    localparam int LAT   = cordic_lat(XY_SZ);
    localparam int OUT_W = XY_SZ + 1;
    localparam int RES_W = ID_W + 2 * OUT_W;
    localparam int CW    = clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } shadow_t;

    // Entry 0 tracks the operand register, entries 1..LAT track the rotator
    // stages, so entry LAT lines up with cx_xout/cx_yout.
    shadow_t          shadow_q [LAT+1];
    shadow_t          shadow_d [LAT+1];
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]    credit_q, credit_d;
    logic [31:0]      angle_q, angle_d;
    logic [XY_SZ-1:0] xin_q, xin_d;
    logic [XY_SZ-1:0] yin_q, yin_d;

    logic             grant_found;
    logic [ID_W-1:0]  grant_id;
    int               scan_idx;
    logic             credit_avail;
    logic             issue;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [RES_W-1:0] fifo_head;
    logic [CW-1:0]    fifo_count;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = (int'(ptr_q) + i) % NREQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(scan_idx);
            end
        end
    end

    assign credit_avail = (credit_q < CW'(FIFO_DEPTH));
    assign issue        = grant_found && credit_avail && !reset;
    assign req_ready    = issue ? (NREQ'(1) << grant_id) : '0;

    assign fifo_pop  = res_valid && res_ready;
    assign fifo_push = shadow_q[LAT].valid;

    // Issue path, shadow shift and credit bookkeeping.
    always_comb begin
        ptr_d    = ptr_q;
        angle_d  = angle_q;
        xin_d    = xin_q;
        yin_d    = yin_q;
        credit_d = credit_q;
        shadow_d[0].valid = issue;
        shadow_d[0].id    = grant_id;
        for (int k = 1; k <= LAT; k++) begin
            shadow_d[k] = shadow_q[k-1];
        end
        if (issue) begin
            ptr_d   = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
            angle_d = req_angle[int'(grant_id)*32 +: 32];
            xin_d   = req_x[int'(grant_id)*XY_SZ +: XY_SZ];
            yin_d   = req_y[int'(grant_id)*XY_SZ +: XY_SZ];
        end
        if (issue && !fifo_pop) begin
            credit_d = credit_q + CW'(1);
        end else if (!issue && fifo_pop) begin
            credit_d = credit_q - CW'(1);
        end
    end

    // State registers; rotator contents are left alone since the shadow
    // valids are cleared on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q    <= '0;
            credit_q <= '0;
            angle_q  <= '0;
            xin_q    <= '0;
            yin_q    <= '0;
            for (int k = 0; k <= LAT; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            angle_q  <= angle_d;
            xin_q    <= xin_d;
            yin_q    <= yin_d;
            shadow_q <= shadow_d;
        end
    end

    // Every buffered result still holds its credit, so the FIFO cannot overrun.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(fifo_full && fifo_push && !fifo_pop));
            assert (fifo_count <= credit_q);
        end
    end

    cordic_res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({shadow_q[LAT].id, cx_xout, cx_yout}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cx_angle  = angle_q;
    assign cx_xin    = xin_q;
    assign cx_yin    = yin_q;
    assign res_valid = !fifo_empty;
    // Outputs read as zero while the FIFO is empty.
    assign {res_id, res_x, res_y} = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched
// Scoreboard bench for cordic_sched with a behavioural rotator behind cx_*.
module tb_cordic_sched;
    import cordic_pkg::*;

    localparam int  NREQ       = 4;
    localparam int  XY_SZ      = 16;
    localparam int  FIFO_DEPTH = 16;
    localparam int  LAT        = 16;
    localparam int  ID_W       = 2;
    localparam int  OUTW       = 17;
    localparam int  TOL        = 4;
    localparam real GAIN       = 1.6467602;
    localparam real PI         = 3.14159265358979;

    typedef struct {
        int id;
        int x;
        int y;
    } expT;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*32-1:0]    req_angle;
    logic [NREQ*XY_SZ-1:0] req_x;
    logic [NREQ*XY_SZ-1:0] req_y;
    logic [31:0]           cx_angle;
    logic [XY_SZ-1:0]      cx_xin;
    logic [XY_SZ-1:0]      cx_yin;
    logic [XY_SZ:0]        cx_xout;
    logic [XY_SZ:0]        cx_yout;
    logic                  res_valid;
    logic                  res_ready;
    logic [ID_W-1:0]       res_id;
    logic [XY_SZ:0]        res_x;
    logic [XY_SZ:0]        res_y;

    int              checks = 0;
    int              errors = 0;
    expT             sbQ[$];
    expT             monExp;
    logic [NREQ-1:0] expReady;
    logic signed [XY_SZ:0] pipeX [LAT];
    logic signed [XY_SZ:0] pipeY [LAT];

    // Hand-computed rotations (gain 1.64676) of each requester's fixed operands:
    // r0: 0 deg, x=0x1000; r1: -90 deg, x=0x0800; r2: +45 deg, x=0x4000; r3: +90 deg, x=0x1000
    int expResX [NREQ] = '{6745, 0, 19078, 0};
    int expResY [NREQ] = '{0, -3373, 19078, 6745};

    cordic_sched #(
        .NREQ       (NREQ),
        .XY_SZ      (XY_SZ),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ID_W       (ID_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_angle (req_angle),
        .req_x     (req_x),
        .req_y     (req_y),
        .cx_angle  (cx_angle),
        .cx_xin    (cx_xin),
        .cx_yin    (cx_yin),
        .cx_xout   (cx_xout),
        .cx_yout   (cx_yout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_x     (res_x),
        .res_y     (res_y)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    // Ideal rotation with CORDIC gain, rounded to nearest.
    function automatic int rotate(input logic [31:0] ang, input logic [15:0] xi,
                                  input logic [15:0] yi, input bit wantY);
        real a, xr, yr, r;
        a  = $itor($signed(ang)) * PI / 2147483648.0;
        xr = $itor($signed(xi));
        yr = $itor($signed(yi));
        if (wantY) r = GAIN * (xr * $sin(a) + yr * $cos(a));
        else       r = GAIN * (xr * $cos(a) - yr * $sin(a));
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(0.5 - r);
    endfunction

    // Rotator stand-in: LAT register stages, no reset, no stall.
    always @(posedge clock) begin
        pipeX[0] <= OUTW'(rotate(cx_angle, cx_xin, cx_yin, 1'b0));
        pipeY[0] <= OUTW'(rotate(cx_angle, cx_xin, cx_yin, 1'b1));
        for (int k = 1; k < LAT; k++) begin
            pipeX[k] <= pipeX[k-1];
            pipeY[k] <= pipeY[k-1];
        end
    end
    assign cx_xout = pipeX[LAT-1];
    assign cx_yout = pipeY[LAT-1];

    task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
        int diff;
        diff = actual - expected;
        if (diff < 0) diff = -diff;
        checks++;
        if (diff > tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", name, actual, expected, tol);
        end
    endtask

    // One stimulus cycle: drive requests, predict the grant and queue its result.
    task automatic applyStimulus(input logic [NREQ-1:0] valid, input int grant);
        expT e;
        req_valid = valid;
        expReady  = (grant >= 0) ? NREQ'(1 << grant) : '0;
        if (grant >= 0) begin
            e.id = grant;
            e.x  = expResX[grant];
            e.y  = expResY[grant];
            sbQ.push_back(e);
        end
        @(posedge clock);
        #1;
        req_valid = '0;
        expReady  = '0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic waitResValid(output int n);
        n = 0;
        while (!res_valid && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput(name, sbQ.size(), 0, 0);
    endtask

    // Grant checker: req_ready must equal the predicted one-hot every cycle.
    always @(negedge clock) begin
        checkOutput("req_ready", int'(req_ready), int'(expReady), 0);
    end

    // Result monitor: every accepted result is matched against the queue head.
    always @(negedge clock) begin
        if (res_valid && res_ready) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got id %0d, expected no result", res_id);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("res_id", int'(res_id), monExp.id, 0);
                checkOutput("res_x", int'($signed(res_x)), monExp.x, TOL);
                checkOutput("res_y", int'($signed(res_y)), monExp.y, TOL);
            end
        end
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int  n;
        int  k;
        bit  sawValid;
        reset     = 1'b1;
        req_valid = '1;
        res_ready = 1'b0;
        expReady  = '0;
        req_angle = {ANGLE_90, ANGLE_45, 32'hC000_0000, 32'h0000_0000};
        req_x     = {16'h1000, 16'h4000, 16'h0800, 16'h1000};
        req_y     = '0;
        idleCycles(3);

        // Reset values, with every requester asking.
        checkOutput("rst_res_valid", int'(res_valid), 0, 0);
        checkOutput("rst_cx_angle", int'(cx_angle), 0, 0);
        checkOutput("rst_cx_xin", int'(cx_xin), 0, 0);
        checkOutput("rst_cx_yin", int'(cx_yin), 0, 0);
        checkOutput("rst_res_id", int'(res_id), 0, 0);
        checkOutput("rst_res_x", int'(res_x), 0, 0);
        checkOutput("rst_res_y", int'(res_y), 0, 0);
        checkOutput("rst_req_ready", int'(req_ready), 0, 0);
        reset     = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;

        // Only requester 3 with pointer 0: immediate grant, pointer wraps to 0.
        applyStimulus(4'b1000, 3);
        waitResValid(n);
        checkOutput("latency_r3", n, 17, 0);
        waitDrain("drain_r3");

        // All requesters valid: grants 0,1,2,3,... and back-to-back results.
        for (int c = 0; c < 12; c++) applyStimulus(4'b1111, c % 4);
        waitResValid(n);
        k = 0;
        while (res_valid && k < 50) begin
            k++;
            @(posedge clock);
            #1;
        end
        checkOutput("burst_len", k, 12, 0);
        waitDrain("drain_burst");

        // Backpressure: 16 credits, then nothing until a pop frees one.
        res_ready = 1'b0;
        for (int c = 0; c < 40; c++) applyStimulus(4'b1111, (c < FIFO_DEPTH) ? c % 4 : -1);
        for (int j = 0; j < 3; j++) begin
            res_ready = 1'b1;
            applyStimulus(4'b1111, -1);
            res_ready = 1'b0;
            applyStimulus(4'b1111, j);
        end
        applyStimulus(4'b1111, -1);
        res_ready = 1'b1;
        waitDrain("drain_backpressure");

        // Reset with three operations in flight drops them all.
        applyStimulus(4'b0001, 0);
        applyStimulus(4'b0010, 1);
        applyStimulus(4'b0100, 2);
        idleCycles(5);
        reset = 1'b1;
        sbQ.delete();
        idleCycles(2);
        reset = 1'b0;
        sawValid = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (res_valid) sawValid = 1'b1;
        end
        checkOutput("post_reset_quiet", int'(sawValid), 0, 0);
        checkOutput("post_reset_credit", int'(dut.credit_q), 0, 0);

        // Single 45-degree op from requester 2 after reset.
        applyStimulus(4'b0100, 2);
        waitResValid(n);
        checkOutput("latency_r2", n, 17, 0);
        waitDrain("drain_r2");

        // Alternating bubbles: pointer at 3, grants 3,0,1,2,3.
        for (int c = 0; c < 10; c++) begin
            if (c % 2 == 0) applyStimulus(4'b1111, (3 + c / 2) % 4);
            else            applyStimulus(4'b0000, -1);
        end
        waitDrain("drain_bubbles");
        idleCycles(30);
        checkOutput("sb_empty", sbQ.size(), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
